// File: rtl/lzc_pkg.sv
// Shared types and defaults for the mantissa normalizer datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lzc_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int EXP_W_DEF = 8;
    localparam int CNT_W_DEF = 16;

    // Shift-amount width for a mantissa of the given width.
    function automatic int count_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

    localparam int COUNT_DEF = count_w(WIDTH_DEF);

    // One input beat as held in the first pipeline stage. Field widths follow
    // the package defaults, so the top must be built with matching WIDTH/EXP_W.
    typedef struct packed {
        logic [WIDTH_DEF-1:0] mant;
        logic [EXP_W_DEF-1:0] exp;
        logic [COUNT_DEF-1:0] lzc;
        logic                 zero;
    } norm_beat_t;

endpackage

// File: rtl/norm_shift_left.sv
// Logarithmic left barrel shifter, zero fill, result truncated to WIDTH bits.
// Latency: combinational, COUNT mux levels.
// Backpressure: none (pure datapath).
// Ports: data (value to shift), shamt (shift amount), shifted (result).
module norm_shift_left #(
    parameter int WIDTH = 16,
    parameter int COUNT = 4
) (
    input  logic [WIDTH-1:0] data,
    input  logic [COUNT-1:0] shamt,
    output logic [WIDTH-1:0] shifted
);

    logic [WIDTH-1:0] stage [COUNT+1];

    assign stage[0] = data;

    // Level i shifts by 2**i when bit i of the shift amount is set.
    for (genvar i = 0; i < COUNT; i++) begin : g_lvl
        assign stage[i+1] = shamt[i]
            ? {stage[i][WIDTH-1-(2**i):0], {(2**i){1'b0}}}
            : stage[i];
    end

    assign shifted = stage[COUNT];

endmodule

// File: rtl/lzc_normalizer.sv
// Two-stage mantissa normalizer: shifts out leading zeros, adjusts exponent, clamps at 0.
// Latency: 2 cycles from accepted input to out_valid; 1 beat/cycle throughput.
// Backpressure: in_ready combinationally follows out_ready; no skid buffer, outputs hold while stalled.
// Ports: in_* (mantissa, biased exponent, leading-zero count, zero flag) with valid/ready;
//        out_* (normalized mantissa, exponent, zero, underflow) with valid/ready;
//        uflow_cnt counts delivered underflow beats and saturates.
module lzc_normalizer
    import lzc_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int EXP_W = EXP_W_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int COUNT = count_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [COUNT-1:0] in_lzc,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_uflow,
    output logic [CNT_W-1:0] uflow_cnt
);

    // Wide enough to hold either operand, so the exponent compare cannot wrap.
    localparam int CMP_W = EXP_W + COUNT + 1;

    norm_beat_t s1_q;
    logic       s1_valid;
    logic       s2_valid;
    logic       s1_adv;
    logic       s2_adv;

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    logic [CMP_W-1:0] e_ext;
    logic [CMP_W-1:0] z_ext;
    logic             uflow_c;
    logic [COUNT-1:0] shamt;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] res_mant;
    logic [EXP_W-1:0] res_exp;

    assign e_ext   = CMP_W'(s1_q.exp);
    assign z_ext   = CMP_W'(s1_q.lzc);
    assign uflow_c = ~s1_q.zero & (z_ext > e_ext);

    // Underflow shifts only by the exponent (partial normalization); since
    // e < z <= WIDTH-1 there, the amount always fits in COUNT bits.
    assign shamt = uflow_c ? COUNT'(e_ext) : COUNT'(z_ext);

    norm_shift_left #(
        .WIDTH (WIDTH),
        .COUNT (COUNT)
    ) u_shift (
        .data    (s1_q.mant),
        .shamt   (shamt),
        .shifted (shifted)
    );

    always_comb begin
        res_mant = shifted;
        res_exp  = EXP_W'(e_ext - z_ext);
        if (s1_q.zero) begin
            res_mant = '0;
            res_exp  = '0;
        end else if (uflow_c) begin
            res_exp  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_q      <= '0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
            uflow_cnt <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q.mant <= in_mant;
                    s1_q.exp  <= in_exp;
                    s1_q.lzc  <= in_lzc;
                    s1_q.zero <= in_zero;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_mant  <= res_mant;
                    out_exp   <= res_exp;
                    out_zero  <= s1_q.zero;
                    out_uflow <= uflow_c;
                end
            end
            if (s2_valid & out_ready & out_uflow & (uflow_cnt != '1)) begin
                uflow_cnt <= uflow_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lzc_normalizer.sv
module tb_lzc_normalizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_mant = '0;
    logic [7:0]  in_exp = '0;
    logic [3:0]  in_lzc = '0;
    logic        in_zero = 1'b0;

    logic        in_ready, out_valid, out_zero, out_uflow;
    logic [15:0] out_mant;
    logic [7:0]  out_exp;
    logic [15:0] uflow_cnt;

    logic        in_ready_s, out_valid_s, out_zero_s, out_uflow_s;
    logic [15:0] out_mant_s;
    logic [7:0]  out_exp_s;
    logic [1:0]  uflow_cnt_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] mant;
        logic [7:0]  exp;
        logic        zero;
        logic        uflow;
    } res_t;

    res_t sb[$];
    int   exp_cnt = 0;

    typedef struct {
        logic [15:0] m; int e; int z; logic zf;
        logic [15:0] xm; logic [7:0] xe; logic xz; logic xu;
    } vec_t;

    vec_t vecs[4] = '{
        '{16'h0010, 20, 11, 1'b0, 16'h8000, 8'd9, 1'b0, 1'b0},
        '{16'h0000, 50,  5, 1'b1, 16'h0000, 8'd0, 1'b1, 1'b0},
        '{16'h0001,  5, 15, 1'b0, 16'h0020, 8'd0, 1'b0, 1'b1},
        '{16'h0100,  7,  7, 1'b0, 16'h8000, 8'd0, 1'b0, 1'b0}
    };

    int sat_exp[5] = '{1, 2, 3, 3, 3};

    lzc_normalizer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp), .in_lzc(in_lzc), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
        .out_exp(out_exp), .out_zero(out_zero), .out_uflow(out_uflow),
        .uflow_cnt(uflow_cnt)
    );

    lzc_normalizer #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_mant(in_mant), .in_exp(in_exp), .in_lzc(in_lzc), .in_zero(in_zero),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_mant(out_mant_s),
        .out_exp(out_exp_s), .out_zero(out_zero_s), .out_uflow(out_uflow_s),
        .uflow_cnt(uflow_cnt_s)
    );

    always #5 clk = ~clk;

    // Reference: normalize by the given count, or clamp at exponent 0.
    function automatic res_t model(input logic [15:0] m, input int e, input int z, input logic zf);
        res_t r;
        r.zero  = zf;
        r.uflow = 1'b0;
        if (zf) begin
            r.mant = '0;
            r.exp  = '0;
        end else if (z <= e) begin
            r.mant = m << z;
            r.exp  = 8'(e - z);
        end else begin
            r.mant  = m << e;
            r.exp   = '0;
            r.uflow = 1'b1;
        end
        return r;
    endfunction

    function automatic int true_lzc(input logic [15:0] m);
        for (int i = 15; i >= 0; i--) if (m[i]) return 15 - i;
        return 0;
    endfunction

    task automatic drive(input logic [15:0] m, input int e, input int z, input logic zf);
        in_mant = m;
        in_exp  = 8'(e);
        in_lzc  = 4'(z);
        in_zero = zf;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_mant !== 16'h0) begin errors++; $display("FAIL reset_out_mant: got %h expected 0", out_mant); end
        checks++; if (out_exp !== 8'h0) begin errors++; $display("FAIL reset_out_exp: got %0d expected 0", out_exp); end
        checks++; if ({out_zero, out_uflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", out_zero, out_uflow); end
        checks++; if (uflow_cnt !== 16'h0) begin errors++; $display("FAIL reset_uflow_cnt: got %0d expected 0", uflow_cnt); end
        checks++; if (uflow_cnt_s !== 2'd0) begin errors++; $display("FAIL reset_uflow_cnt_sat: got %0d expected 0", uflow_cnt_s); end
        rst = 1'b0;
        sb.delete();
        exp_cnt = 0;
    endtask

    task automatic test_directed();
        out_ready = 1'b1;
        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].m, vecs[k].e, vecs[k].z, vecs[k].zf);
            in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_in_ready[%0d]: got %b expected 1", k, in_ready); end
            checks++; if (uflow_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL dir_uflow_cnt[%0d]: got %0d expected %0d", k, uflow_cnt, exp_cnt); end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_latency_early[%0d]: out_valid got %b expected 0", k, out_valid); end
            @(negedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir_latency[%0d]: out_valid got %b expected 1", k, out_valid); end
            checks++;
            if ({out_mant, out_exp, out_zero, out_uflow} !== {vecs[k].xm, vecs[k].xe, vecs[k].xz, vecs[k].xu}) begin
                errors++;
                $display("FAIL dir_result[%0d]: got mant=%h exp=%0d zero=%b uflow=%b expected mant=%h exp=%0d zero=%b uflow=%b",
                         k, out_mant, out_exp, out_zero, out_uflow, vecs[k].xm, vecs[k].xe, vecs[k].xz, vecs[k].xu);
            end
            if (vecs[k].xu) exp_cnt++;
        end
        @(negedge clk);
        #1;
        checks++; if (uflow_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL dir_uflow_cnt_end: got %0d expected %0d", uflow_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        logic [15:0] bm[4] = '{16'h0010, 16'h0100, 16'h0001, 16'h0F00};
        int          be[4] = '{20, 7, 5, 30};
        int          bz[4] = '{11, 7, 15, 4};
        res_t        ra;
        res_t        r;
        int          idx = 0;
        int          ndone = 0;
        int          c = 0;
        ra = model(bm[0], be[0], bz[0], 1'b0);
        while (ndone < 4 && c < 30) begin
            @(negedge clk);
            out_ready = (c >= 3);
            if (idx < 4) begin
                drive(bm[idx], be[idx], bz[idx], 1'b0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (in_ready !== !(sb.size() == 2 && !out_ready)) begin
                errors++; $display("FAIL bp_in_ready[c=%0d]: got %b expected %b", c, in_ready, !(sb.size() == 2 && !out_ready));
            end
            if (c == 2) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_drop: got %b expected 0", in_ready); end
                checks++; if (out_mant !== ra.mant) begin errors++; $display("FAIL bp_stall_hold: out_mant got %h expected %h", out_mant, ra.mant); end
            end
            checks++; if (uflow_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL bp_uflow_cnt[c=%0d]: got %0d expected %0d", c, uflow_cnt, exp_cnt); end
            if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL bp_spurious[c=%0d]: out_valid=1 with nothing expected", c);
                end else begin
                    r = sb[0];
                    if ({out_mant, out_exp, out_zero, out_uflow} !== {r.mant, r.exp, r.zero, r.uflow}) begin
                        errors++;
                        $display("FAIL bp_data[c=%0d]: got mant=%h exp=%0d uflow=%b expected mant=%h exp=%0d uflow=%b",
                                 c, out_mant, out_exp, out_uflow, r.mant, r.exp, r.uflow);
                    end
                    if (out_ready) begin
                        void'(sb.pop_front());
                        ndone++;
                        if (r.uflow) exp_cnt++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_mant, int'(in_exp), int'(in_lzc), in_zero));
                idx++;
            end
            c++;
        end
        in_valid = 1'b0;
        checks++; if (ndone !== 4 || sb.size() != 0) begin errors++; $display("FAIL bp_count: delivered %0d expected 4, left %0d", ndone, sb.size()); end
    endtask

    task automatic test_random();
        res_t        r;
        logic [15:0] m;
        int          e, z, sat;
        logic        zf;
        logic        pending = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            out_ready = (c >= 500) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (!pending) begin
                if (c < 500 && $urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 9) == 0) begin
                        m = '0; zf = 1'b1; z = $urandom_range(0, 15);
                    end else begin
                        m = 16'($urandom) >> $urandom_range(0, 15);
                        if (m == 0) m = 16'h0001;
                        zf = 1'b0;
                        z = true_lzc(m);
                        if ($urandom_range(0, 7) == 0) z = $urandom_range(0, 15);
                    end
                    e = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 16) : $urandom_range(0, 255);
                    drive(m, e, z, zf);
                    in_valid = 1'b1;
                    pending  = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            sat = (exp_cnt > 3) ? 3 : exp_cnt;
            checks++;
            if (in_ready !== !(sb.size() == 2 && !out_ready)) begin
                errors++; $display("FAIL rand_in_ready[c=%0d]: got %b expected %b", c, in_ready, !(sb.size() == 2 && !out_ready));
            end
            checks++; if (uflow_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL rand_uflow_cnt[c=%0d]: got %0d expected %0d", c, uflow_cnt, exp_cnt); end
            checks++; if (uflow_cnt_s !== 2'(sat)) begin errors++; $display("FAIL rand_uflow_sat[c=%0d]: got %0d expected %0d", c, uflow_cnt_s, sat); end
            if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL rand_spurious[c=%0d]: out_valid=1 with nothing expected", c);
                end else begin
                    r = sb[0];
                    if ({out_mant, out_exp, out_zero, out_uflow} !== {r.mant, r.exp, r.zero, r.uflow}) begin
                        errors++;
                        $display("FAIL rand_data[c=%0d]: got mant=%h exp=%0d zero=%b uflow=%b expected mant=%h exp=%0d zero=%b uflow=%b",
                                 c, out_mant, out_exp, out_zero, out_uflow, r.mant, r.exp, r.zero, r.uflow);
                    end
                    if (out_ready) begin
                        void'(sb.pop_front());
                        if (r.uflow) exp_cnt++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_mant, int'(in_exp), int'(in_lzc), in_zero));
                pending = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++; if (sb.size() != 0 || pending) begin errors++; $display("FAIL rand_drain: %0d beats undelivered expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        res_t r;
        out_ready = 1'b0;
        @(negedge clk); drive(16'h0001, 3, 15, 1'b0); in_valid = 1'b1;
        @(negedge clk); drive(16'h0040, 40, 9, 1'b0); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        #1;
        checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL rstmid_full: valid/ready got %b%b expected 10", out_valid, in_ready); end
        drive(16'h0200, 60, 6, 1'b0);
        in_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        checks++; if (uflow_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_uflow_cnt: got %0d expected 0", uflow_cnt); end
        sb.delete();
        exp_cnt = 0;
        repeat (2) begin
            @(negedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_discard: out_valid got %b expected 0", out_valid); end
        end
        out_ready = 1'b1;
        r = model(16'h0300, 12, 6, 1'b0);
        @(negedge clk); drive(16'h0300, 12, 6, 1'b0); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_first_early: out_valid got %b expected 0", out_valid); end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_first_latency: out_valid got %b expected 1", out_valid); end
        checks++;
        if ({out_mant, out_exp} !== {r.mant, r.exp}) begin
            errors++; $display("FAIL rstmid_first_data: got mant=%h exp=%0d expected mant=%h exp=%0d", out_mant, out_exp, r.mant, r.exp);
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(16'h0001, k, 15, 1'b0);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            if (k == 0) out_ready = 1'b0;
            @(negedge clk); #1;
            checks++; if ({out_valid_s, out_uflow_s} !== 2'b11) begin errors++; $display("FAIL sat_beat[%0d]: valid/uflow got %b%b expected 11", k, out_valid_s, out_uflow_s); end
            if (k == 0) begin
                repeat (2) begin
                    @(negedge clk); #1;
                    checks++; if (uflow_cnt_s !== 2'd0) begin errors++; $display("FAIL sat_stalled: got %0d expected 0", uflow_cnt_s); end
                end
                out_ready = 1'b1;
            end
            @(negedge clk); #1;
            checks++; if (uflow_cnt_s !== 2'(sat_exp[k])) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", k, uflow_cnt_s, sat_exp[k]); end
            checks++; if (uflow_cnt !== 16'(k + 1)) begin errors++; $display("FAIL sat_wide_cnt[%0d]: got %0d expected %0d", k, uflow_cnt, k + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
